// File: rtl/piso_tx_pkg.sv
// Shared definitions for the parallel-in serial-out transmitter.
package piso_tx_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/dff_cell.sv
// One-bit D register with synchronous set and clear; set dominates clear.
module dff_cell (
  input  logic i_clk,
  input  logic i_set,
  input  logic i_clr,
  input  logic i_d,
  output logic o_q
);

  logic r_q = 1'b0;

  always_ff @(posedge i_clk) begin
    if (i_set) begin
      r_q <= 1'b1;
    end else if (i_clr) begin
      r_q <= 1'b0;
    end else begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: accepts a word when idle, shifts it out
// one bit per clock, then pulses done for one cycle.
module piso_tx
  import piso_tx_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             valid,
  input  logic [WIDTH-1:0] din,
  output logic             ready,
  output logic             sout,
  output logic             sout_n,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int OUT_IDX = MSB_FIRST ? WIDTH - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           r_state = ST_IDLE;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt = '0;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_accept;
  logic             w_shift;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_set;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] w_d;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    ready        = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    w_accept     = 1'b0;
    w_shift      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        ready = 1'b1;
        if (valid && !clr) begin
          w_accept     = 1'b1;
          w_cnt_next   = '0;
          w_state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        busy    = 1'b1;
        w_shift = 1'b1;
        if (r_cnt == CNT_LAST) begin
          w_cnt_next   = '0;
          w_state_next = ST_DONE;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      ST_DONE: begin
        done         = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Loading uses the cell set/clear pins, so the D path only handles shift/hold.
  // After WIDTH shifts the register is all zero, keeping sout low outside SHIFT.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic w_nb;
      if (MSB_FIRST) begin : g_msb
        if (gi == 0) begin : g_end
          assign w_nb = 1'b0;
        end else begin : g_mid
          assign w_nb = w_q[gi-1];
        end
      end else begin : g_lsb
        if (gi == WIDTH - 1) begin : g_end
          assign w_nb = 1'b0;
        end else begin : g_mid
          assign w_nb = w_q[gi+1];
        end
      end

      assign w_set[gi] = w_accept & din[gi];
      assign w_clr[gi] = clr | (w_accept & ~din[gi]);
      assign w_d[gi]   = w_shift ? w_nb : w_q[gi];

      dff_cell u_cell (
        .i_clk (clk),
        .i_set (w_set[gi]),
        .i_clr (w_clr[gi]),
        .i_d   (w_d[gi]),
        .o_q   (w_q[gi])
      );
    end
  endgenerate

  assign sout   = w_q[OUT_IDX];
  assign sout_n = ~w_q[OUT_IDX];

endmodule

// File: tb/tb_piso_tx.sv
// Self-checking bench: an MSB-first and an LSB-first instance share stimulus;
// a cycle model plus a word scoreboard check both.
module tb_piso_tx;

  localparam int W = 8;

  logic         clk   = 1'b0;
  logic         clr   = 1'b1;
  logic         valid = 1'b0;
  logic [W-1:0] din   = '0;

  logic ready_m, sout_m, sout_n_m, busy_m, done_m;
  logic ready_l, sout_l, sout_n_l, busy_l, done_l;

  always #5 clk = ~clk;

  piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) u_dut_msb (
    .clk    (clk),
    .clr    (clr),
    .valid  (valid),
    .din    (din),
    .ready  (ready_m),
    .sout   (sout_m),
    .sout_n (sout_n_m),
    .busy   (busy_m),
    .done   (done_m)
  );

  piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) u_dut_lsb (
    .clk    (clk),
    .clr    (clr),
    .valid  (valid),
    .din    (din),
    .ready  (ready_l),
    .sout   (sout_l),
    .sout_n (sout_n_l),
    .busy   (busy_l),
    .done   (done_l)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: 0 idle, 1 shift, 2 done
  int           m_st   = 0;
  int           m_cnt  = 0;
  logic [W-1:0] m_word = '0;
  logic [W-1:0] sb_q[$];
  logic [W-1:0] col_m  = '0;
  logic [W-1:0] col_l  = '0;
  int           n_done = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    logic         e_m;
    logic         e_l;
    logic [W-1:0] exp_w;
    @(posedge clk);
    if (clr) begin
      if (m_st == 1) void'(sb_q.pop_back());
      m_st  = 0;
      m_cnt = 0;
      col_m = '0;
      col_l = '0;
    end else begin
      case (m_st)
        0: if (valid) begin
          m_word = din;
          m_cnt  = 0;
          m_st   = 1;
          sb_q.push_back(din);
        end
        1: if (m_cnt == W - 1) m_st = 2; else m_cnt++;
        default: m_st = 0;
      endcase
    end
    #1;
    e_m = (m_st == 1) ? m_word[W-1-m_cnt] : 1'b0;
    e_l = (m_st == 1) ? m_word[m_cnt]     : 1'b0;
    check("ctl_msb", {ready_m, busy_m, done_m, sout_m}, {(m_st == 0), (m_st == 1), (m_st == 2), e_m});
    check("ctl_lsb", {ready_l, busy_l, done_l, sout_l}, {(m_st == 0), (m_st == 1), (m_st == 2), e_l});
    check("soutn_msb", sout_n_m, {~sout_m});
    check("soutn_lsb", sout_n_l, {~sout_l});
    if (busy_m) col_m = {col_m[W-2:0], sout_m};
    if (busy_l) col_l = {sout_l, col_l[W-1:1]};
    if (done_m) begin
      n_done++;
      if (sb_q.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        exp_w = sb_q.pop_front();
        check("word_msb", col_m, exp_w);
        check("word_lsb", col_l, exp_w);
        $display("tx word=%02h msb_rx=%02h lsb_rx=%02h", exp_w, col_m, col_l);
      end
      col_m = '0;
      col_l = '0;
    end
  endtask

  initial begin
    logic [7:0]  rec_m;
    logic [7:0]  rec_l;
    logic [19:0] rec_s;
    logic [19:0] rec_d;
    int          nd;

    #1;
    check("powerup", {ready_m, busy_m, done_m, sout_m, sout_n_m}, 5'b10001);

    // clr dominates valid at the same edge
    clr = 1'b1; valid = 1'b1; din = 8'hAA;
    step();
    check("clr_valid", {ready_m, busy_m, ready_l, busy_l}, 4'b1010);
    clr = 1'b0; valid = 1'b0;
    step();
    check("clr_valid_idle", {ready_m, busy_m}, 2'b10);

    // single word 0x1E, exact cycle timing
    valid = 1'b1; din = 8'h1E;
    for (int k = 0; k < 8; k++) begin
      step();
      if (k == 0) valid = 1'b0;
      rec_m[7-k] = sout_m;
      rec_l[7-k] = sout_l;
    end
    check("seq_msb", rec_m, 8'b00011110);
    check("seq_lsb", rec_l, 8'b01111000);
    step();
    check("done_c9", {done_m, done_l, busy_m}, 3'b110);
    step();
    check("ready_c10", {ready_m, ready_l, done_m}, 3'b110);

    // back-to-back with valid held; din changes while shifting
    nd = n_done;
    valid = 1'b1; din = 8'hFF;
    for (int k = 0; k < 20; k++) begin
      step();
      if (k == 0) din = 8'h00;
      rec_s[19-k] = sout_m;
      rec_d[19-k] = done_m;
    end
    valid = 1'b0;
    check("b2b_sout", rec_s, 20'hFF000);
    check("b2b_done", rec_d, 20'h00802);
    check("b2b_ndone", n_done - nd, 2);

    // clr in cycle 4 of a 0xFF transfer
    nd = n_done;
    valid = 1'b1; din = 8'hFF;
    step();
    valid = 1'b0;
    step();
    step();
    step();
    clr = 1'b1;
    step();
    check("abort_c5", {sout_m, busy_m, ready_m, sout_l, busy_l, ready_l}, 6'b001001);
    clr = 1'b0;
    repeat (12) step();
    check("abort_nodone", n_done - nd, 0);

    // random traffic, random valid during SHIFT/DONE, din toggling
    repeat (200) begin
      valid = ($urandom_range(0, 3) == 0);
      din   = W'($urandom);
      step();
    end
    valid = 1'b0;
    repeat (12) step();
    check("sb_drain", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 Parameter WIDTH, default 8, sets the number of data bits per word (legal range 2..32).
REQ-002 Parameter MSB_FIRST, default 1: 1 sends bit WIDTH-1 first, 0 sends bit 0 first.
REQ-003 clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-004 clr  input  1  reset, synchronous and active-high.
REQ-005 valid  input  1  din holds a word to transmit.
REQ-006 din  input  WIDTH  parallel word, sampled only on accept.
REQ-007 ready  output  1  block can accept a word this cycle.
REQ-008 sout  output  1  serial data out.
REQ-009 sout_n  output  1  always the complement of sout.
REQ-010 busy  output  1  a word is being shifted out.
REQ-011 done  output  1  one-cycle pulse after the last bit.

Function
REQ-012 States: IDLE, SHIFT, DONE; the encoding is free.
REQ-013 IDLE outputs: ready=1, busy=0, done=0, sout=0.
REQ-014 Accept occurs at a rising edge with state IDLE, valid=1 and clr=0.
REQ-015 On accept: the shift register loads din, the bit counter loads 0, and the state goes to SHIFT.
REQ-016 SHIFT outputs: ready=0, busy=1, done=0.
REQ-017 In SHIFT, sout SHALL be taken directly from a register bit (MSB or LSB per MSB_FIRST), not decoded through logic.
REQ-018 Timing: bit k of the transmit order (k=0..WIDTH-1) appears on sout during cycle k+1 after the accept edge.
REQ-019 Each SHIFT edge shifts the register one place toward the output end, fills the vacated bit with 0, and increments the counter.
REQ-020 At the SHIFT edge where the counter equals WIDTH-1, the state goes to DONE.
REQ-021 DONE outputs: done=1, ready=0, busy=0, sout=0, for exactly one cycle; the state then goes to IDLE.
REQ-022 Throughput: a word accepted at edge N yields done high in cycle WIDTH+1 and ready high again in cycle WIDTH+2.
REQ-023 valid while the state is SHIFT or DONE is ignored; din is not sampled and no word is queued.
REQ-024 Back-to-back transfers: valid held high continuously produces one word every WIDTH+2 cycles, with no bit lost or repeated.
REQ-025 The counter is ceil(log2(WIDTH)) bits wide and never counts past WIDTH-1.
REQ-026 din changing during SHIFT has no effect on the word in flight.

Reset
REQ-027 With clr=1 at an edge, the state goes to IDLE, the shift register and counter clear to 0, and the outputs become ready=1, busy=0, done=0, sout=0, sout_n=1.
REQ-028 clr overrides valid at the same edge; no accept occurs.
REQ-029 clr during SHIFT or DONE aborts the word; no done pulse is issued for it.
REQ-030 Power-up register initial values equal the reset values.

Structure
REQ-031 A shared package holds the state enumeration and the default WIDTH constant.
REQ-032 One sub-module, dff_cell, SHALL be used: a 1-bit D register with synchronous set and clear (set dominant), instantiated WIDTH times for the shift register.
REQ-033 The FSM and counter live in piso_tx itself.

Verification
REQ-034 WIDTH=8, MSB_FIRST=1, din=0x1E accepted at edge 0 -> sout reads 0,0,0,1,1,1,1,0 in cycles 1-8, done=1 in cycle 9, ready=1 in cycle 10.
REQ-035 MSB_FIRST=0, din=0x1E -> sout reads 0,1,1,1,1,0,0,0 in cycles 1-8, done in cycle 9.
REQ-036 valid held high with din=0xFF then 0x00 -> two words 10 cycles apart; sout is eight 1s, then 0 for 2 cycles, then eight 0s; exactly two done pulses.
REQ-037 clr asserted in cycle 4 of a 0xFF transfer -> in cycle 5 sout=0, busy=0, ready=1, and no done pulse follows.
REQ-038 clr=1 and valid=1 at the same edge -> no accept; the state remains IDLE.
REQ-039 At every cycle of all scenarios -> sout_n == ~sout.
